// File: rtl/frodo_hash_pkg.sv
// frodo_hash_pkg: word and lane widths shared by keccak, the lane buffer and the sampler.
package frodo_hash_pkg;
   localparam int HASH_WORD_W   = 64;
   localparam int SAMPLE_LANE_W = 16;
   localparam int HASH_LANES    = HASH_WORD_W / SAMPLE_LANE_W;
endpackage

// File: rtl/hash_word_fifo.sv
// hash_word_fifo: DEPTH x DATA_W register FIFO with occupancy count and synchronous flush.
module hash_word_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              wr, rd;
   assign full = count == CW'(DEPTH);
   assign wr   = push && !full && !flush;
   assign rd   = pop && count != '0 && !flush;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= push_data;
   // Pointers wrap modulo DEPTH because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         count  <= flush ? '0 : count + CW'(wr) - CW'(rd);
         wr_ptr <= flush ? '0 : wr_ptr + AW'(wr);
         rd_ptr <= flush ? '0 : rd_ptr + AW'(rd);
      end
endmodule

// File: rtl/hash_lane_buffer.sv
// hash_lane_buffer: buffers keccak squeeze words and serialises them into sampler lanes.
module hash_lane_buffer
   import frodo_hash_pkg::*;
#(
   parameter int DATA_W = HASH_WORD_W,
   parameter int LANE_W = SAMPLE_LANE_W,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [LANE_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] word_count,
   output logic [1:0]                 lane_idx,
   output logic [15:0]                lanes_served
);
   localparam int LANES = DATA_W / LANE_W;
   logic [DATA_W-1:0] head;
   logic              full, push, hs, last;
   assign in_ready  = !full;
   assign out_valid = word_count != '0;
   assign push      = in_valid && in_ready;
   assign hs        = out_valid && out_ready;
   assign last      = lane_idx == 2'(LANES-1);
   assign out_data  = out_valid ? head[LANE_W*lane_idx +: LANE_W] : '0;
   hash_word_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .push      (push),
      .push_data (in_data),
      .pop       (hs && last),
      .head      (head),
      .count     (word_count),
      .full      (full)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         lane_idx     <= '0;
         lanes_served <= '0;
      end else begin
         lane_idx     <= flush ? '0 : hs ? (last ? '0 : lane_idx + 2'd1) : lane_idx;
         lanes_served <= flush ? '0 : lanes_served + 16'(hs);
      end
endmodule

// File: tb/tb_hash_lane_buffer.sv
// tb_hash_lane_buffer: directed self-checking bench for hash_lane_buffer.
module tb_hash_lane_buffer;
   logic        clk, rstn, flush, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] in_data;
   logic [15:0] out_data, lanes_served;
   logic [1:0]  word_count, lane_idx;
   int tests, fails;

   hash_lane_buffer dut (
      .clk          (clk),
      .rstn         (rstn),
      .flush        (flush),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .word_count   (word_count),
      .lane_idx     (lane_idx),
      .lanes_served (lanes_served)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_lane, next_word, cyc;
      tests = 0;
      fails = 0;
      rstn = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
      #3;
      check("rst_wc", word_count, 0);
      check("rst_lane", lane_idx, 0);
      check("rst_served", lanes_served, 0);
      check("rst_ovalid", out_valid, 0);
      check("rst_odata", out_data, 0);
      check("rst_iready", in_ready, 1);
      rstn = 1;
      tick;
      // single word, continuous drain
      in_data = 64'h4444_3333_2222_1111; in_valid = 1; out_ready = 1;
      tick;
      in_valid = 0;
      for (int i = 0; i < 4; i++) begin
         check("t1_ovalid", out_valid, 1);
         check("t1_lane", out_data, 64'(16'h1111 * (i + 1)));
         tick;
      end
      check("t1_empty", out_valid, 0);
      check("t1_served", lanes_served, 4);
      check("t1_iready", in_ready, 1);
      // fill to full
      out_ready = 0; in_valid = 1;
      in_data = 64'h8888_7777_6666_5555;
      tick;
      in_data = 64'hDDDD_CCCC_BBBB_9999;
      tick;
      check("t2_wc_full", word_count, 2);
      check("t2_iready", in_ready, 0);
      in_data = 64'hDEAD_DEAD_DEAD_DEAD;
      tick;
      in_valid = 0;
      check("t2_wc_ignored", word_count, 2);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         check("t2_lane", out_data, 64'(16'h5555 + 16'h1111 * i));
         tick;
      end
      check("t2_wc_after", word_count, 1);
      check("t2_iready_after", in_ready, 1);
      check("t2_next_head", out_data, 16'h9999);
      check("t2_served", lanes_served, 8);
      // simultaneous push and pop on the last lane
      tick; tick; tick;
      check("t3_lane3", lane_idx, 3);
      check("t3_data3", out_data, 16'hDDDD);
      in_valid = 1; in_data = 64'h0123_4567_89AB_CDEF;
      tick;
      in_valid = 0;
      check("t3_wc", word_count, 1);
      check("t3_lane0", lane_idx, 0);
      check("t3_data", out_data, 16'hCDEF);
      check("t3_served", lanes_served, 12);
      tick; tick; tick; tick;
      check("t3_drained", word_count, 0);
      // pointer wrap: 8 words with random stalls
      exp_lane = 0; next_word = 0; cyc = 0;
      while (exp_lane < 32 && cyc < 500) begin
         in_valid  = next_word < 8;
         in_data   = {16'(16'h0A00 + next_word*4 + 3), 16'(16'h0A00 + next_word*4 + 2),
                      16'(16'h0A00 + next_word*4 + 1), 16'(16'h0A00 + next_word*4)};
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            check("t4_lane", out_data, 64'(16'h0A00 + exp_lane));
            exp_lane++;
         end
         if (in_valid && in_ready) next_word++;
         tick;
         check("t4_wc_max", 64'(word_count <= 2), 1);
         cyc++;
      end
      in_valid = 0; out_ready = 0;
      check("t4_all_lanes", exp_lane, 32);
      check("t4_served", lanes_served, 48);
      check("t4_empty", word_count, 0);
      // flush mid-word
      in_valid = 1; in_data = 64'h4A4A_3A3A_2A2A_1A1A;
      tick;
      in_valid = 0; out_ready = 1;
      tick; tick;
      check("t5_lane2", lane_idx, 2);
      check("t5_data2", out_data, 16'h3A3A);
      flush = 1; in_valid = 1; in_data = 64'hEEEE_EEEE_EEEE_EEEE;
      tick;
      flush = 0; in_valid = 0;
      check("t5_wc", word_count, 0);
      check("t5_lane", lane_idx, 0);
      check("t5_served", lanes_served, 0);
      check("t5_ovalid", out_valid, 0);
      check("t5_odata", out_data, 0);
      tick;
      check("t5_dropped", word_count, 0);
      // async reset with two words held
      out_ready = 0; in_valid = 1;
      in_data = 64'h1111_1111_1111_1111;
      tick;
      in_data = 64'h2222_2222_2222_2222;
      tick;
      in_valid = 0;
      check("t6_wc_full", word_count, 2);
      #2 rstn = 0;
      #1;
      check("t6_iready", in_ready, 1);
      check("t6_ovalid", out_valid, 0);
      check("t6_wc", word_count, 0);
      check("t6_odata", out_data, 0);
      #2 rstn = 1;
      in_valid = 1; in_data = 64'hF004_F003_F002_F001; out_ready = 1;
      tick;
      in_valid = 0;
      for (int i = 0; i < 4; i++) begin
         check("t6_resume", out_data, 64'(16'hF001 + i));
         tick;
      end
      check("t6_served", lanes_served, 4);
      check("t6_end_empty", out_valid, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
